// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with arbitrary DEPTH, programmable almost-full/almost-empty levels and overflow/underflow pulses.
// Define FIFO_SYNC_FWFT_EN for first-word-fall-through reads; otherwise data_out is registered with 1-clock latency.
module fifo_sync_flags #(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 1,
    localparam int CW      = $clog2(DEPTH) + 1,
    localparam int PW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             rd_en,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    counter_status,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, empty_q, almost_full_q, almost_empty_q;
    logic             overflow_q, underflow_q;
    logic             rd_acc, wr_acc;

    // A write into a full FIFO is still accepted when a read frees the head slot in the same cycle.
    always_comb begin
        rd_acc   = rd_en & ~empty_q;
        wr_acc   = wr_en & (~full_q | rd_acc);

        wr_ptr_d = wr_ptr_q;
        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end

        rd_ptr_d = rd_ptr_q;
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end

        count_d = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            full_q         <= (count_d == CW'(DEPTH));
            empty_q        <= (count_d == '0);
            almost_full_q  <= (count_d >= CW'(AF_LEVEL));
            almost_empty_q <= (count_d <= CW'(AE_LEVEL));
            overflow_q     <= wr_en & ~wr_acc;
            underflow_q    <= rd_en & empty_q;
        end
    end

`ifdef FIFO_SYNC_FWFT_EN
    // Head word is shown directly; zero while empty so reset still presents 0.
    assign data_out = empty_q ? '0 : mem_q[rd_ptr_q];
`else
    logic [WIDTH-1:0] data_out_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q <= '0;
        end else if (rd_acc) begin
            data_out_q <= mem_q[rd_ptr_q];
        end
    end

    assign data_out = data_out_q;
`endif

    assign full           = full_q;
    assign empty          = empty_q;
    assign almost_full    = almost_full_q;
    assign almost_empty   = almost_empty_q;
    assign counter_status = count_q;
    assign overflow       = overflow_q;
    assign underflow      = underflow_q;

endmodule
